myrisc16_loader: RTL
====================

// Module: myrisc16_loader
// PURPOSE
//  Boot-image loader upstream of the myrisc16 core. It takes a byte stream (valid/ready),
//  parses a framed image, and writes 16-bit words into the core's instruction/data memory.
//  It holds the core in reset (cpu_rstn low) until a checksum-verified load completes.
//  After the core halts, a new image may be loaded.
// PARAMETERS
//  SYNC_BYTE  8'hA5  frame start marker
//  RST_HOLD   4      cycles cpu_rstn stays low after checksum pass (1..255)
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  rst        in   1   asynchronous active-high reset
//  in_data    in   8   stream byte
//  in_valid   in   1   in_data valid
//  in_ready   out  1   loader accepts byte; transfer = in_valid & in_ready
//  mem_we     out  1   one-cycle word write strobe to core memory
//  mem_addr   out  16  word address of write
//  mem_wdata  out  16  write data {hi_byte, lo_byte}
//  cpu_halt   in   1   halt output of core
//  cpu_rstn   out  1   active-low reset to core
//  busy       out  1   frame in progress (ADDR_LO..CSUM)
//  load_done  out  1   last load passed and core released
//  error      out  1   last frame failed checksum
// BEHAVIOUR
//  Frame (after SYNC_BYTE): addr_lo, addr_hi, cnt_lo, cnt_hi (word count N), 2N data bytes
//    (lo first per word), csum byte = XOR of all 2N data bytes (0x00 when N=0).
//  Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rstn=0, busy=0,
//    load_done=0, error=0; state=IDLE.
//  States / transitions (advance only on an accepted byte unless noted):
//   IDLE:   byte==SYNC_BYTE -> ADDR_LO; else discard, stay.
//   ADDR_LO -> ADDR_HI -> CNT_LO -> CNT_HI. On CNT_HI, go to DATA_LO if N!=0, else CSUM.
//   DATA_LO: latch lo -> DATA_HI.
//   DATA_HI: cycle after accept: mem_we=1, mem_addr=cur_addr, mem_wdata={byte,lo}.
//            cur_addr+=1 (16-bit wrap, 0xFFFF->0x0000); remaining-=1.
//            Next state: remaining==0 -> CSUM, else DATA_LO.
//   CSUM:  byte==running XOR -> HOLD (error=0). Otherwise -> ERROR (error=1, load_done=0).
//   HOLD:  in_ready=0; counts RST_HOLD cycles with cpu_rstn=0, then -> RUN.
//   RUN:   cpu_rstn=1, load_done=1. Bytes are accepted and discarded.
//          If cpu_halt=1 and an accepted byte==SYNC_BYTE: cpu_rstn=0 next cycle,
//          load_done=0 -> ADDR_LO. Sync with cpu_halt=0 is ignored.
//   ERROR: cpu_rstn=0. A SYNC_BYTE restarts the frame (-> ADDR_LO, error cleared).
//  cpu_rstn=0 in every state except RUN. Entering ADDR_LO from any state clears the
//    running XOR and load_done.
//  Write pipelining: one byte per cycle is sustained. mem_we is never high on two
//    consecutive cycles, since each word needs two bytes.
//  in_valid gaps may occur anywhere. State holds, nothing times out.
//  rst asserted mid-frame: immediate return to reset values. Partial words are not written.
//    Words already written stay in memory.
//  busy=1 in ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, DATA_LO, DATA_HI, CSUM.
// TESTING
//  1 Stream A5 10 00 02 00 34 12 CD AB 40
//    -> writes (0x0010,0x1234), (0x0011,0xABCD).
//    -> cpu_rstn rises RST_HOLD+1 cycles after csum accept; load_done=1.
//  2 Same frame, csum 41 -> no cpu release, error=1, cpu_rstn=0.
//    Then a valid frame -> error=0, load_done=1.
//  3 A5 FF FF 02 00 01 00 02 00 03 -> writes (0xFFFF,0x0001), (0x0000,0x0002); address wraps.
//  4 A5 00 01 00 00 00 (N=0) -> no mem_we, core released.
//    The same frame with csum 01 -> error.
//  5 In RUN: A5 with cpu_halt=0 ignored (cpu_rstn stays 1).
//    Raise cpu_halt, send A5 -> cpu_rstn=0 next cycle, new frame loads.
//  6 Random in_valid gaps on test 1 -> identical writes.
//    rst pulse after 5 data bytes -> all outputs at reset values, no 3rd word written.

Source files
------------

// File: rtl/myrisc16_loader_if.sv
// Byte-stream, core-memory write and core-control signals of the myrisc16 boot loader.
// The master modport is the environment side; the slave modport is the loader.
interface myrisc16_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_halt;
  logic        cpu_rstn;
  logic        busy;
  logic        load_done;
  logic        error;

  modport master (
    output in_data, in_valid, cpu_halt,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rstn, busy, load_done, error
  );

  modport slave (
    input  in_data, in_valid, cpu_halt,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_rstn, busy, load_done, error
  );
endinterface

// File: rtl/myrisc16_loader.sv
// Boot-image loader: parses a framed byte stream, writes 16-bit words to core memory and
// holds the core in reset until a checksum-verified image has been loaded.
module myrisc16_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned RST_HOLD  = 4
) (
  input logic              clk,
  input logic              rst,
  myrisc16_loader_if.slave bus
);

  typedef enum logic [3:0] {
    StIdle, StAddrLo, StAddrHi, StCntLo, StCntHi, StDataLo, StDataHi, StCsum,
    StHold, StRun, StError
  } state_e;

  localparam logic [7:0] HoldLast = 8'(RST_HOLD - 1);

  state_e      state_q, state_d;
  logic [15:0] cur_addr_q, cur_addr_d;
  logic [15:0] remaining_q, remaining_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        released_q, released_d;
  logic        error_q, error_d;
  logic        in_ready;
  logic        accept;
  logic        is_sync;

  assign in_ready = (state_q != StHold);
  assign accept   = bus.in_valid & in_ready;
  assign is_sync  = (bus.in_data == SYNC_BYTE);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    lo_d        = lo_q;
    csum_d      = csum_q;
    hold_cnt_d  = hold_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    error_d     = error_q;

    unique case (state_q)
      StIdle: if (accept && is_sync) state_d = StAddrLo;
      StAddrLo: if (accept) begin
        cur_addr_d[7:0] = bus.in_data;
        state_d         = StAddrHi;
      end
      StAddrHi: if (accept) begin
        cur_addr_d[15:8] = bus.in_data;
        state_d          = StCntLo;
      end
      StCntLo: if (accept) begin
        remaining_d[7:0] = bus.in_data;
        state_d          = StCntHi;
      end
      StCntHi: if (accept) begin
        remaining_d[15:8] = bus.in_data;
        state_d = ({bus.in_data, remaining_q[7:0]} != 16'd0) ? StDataLo : StCsum;
      end
      StDataLo: if (accept) begin
        lo_d    = bus.in_data;
        csum_d  = csum_q ^ bus.in_data;
        state_d = StDataHi;
      end
      StDataHi: if (accept) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = cur_addr_q;
        mem_wdata_d = {bus.in_data, lo_q};
        cur_addr_d  = cur_addr_q + 16'd1;
        remaining_d = remaining_q - 16'd1;
        csum_d      = csum_q ^ bus.in_data;
        state_d     = (remaining_q == 16'd1) ? StCsum : StDataLo;
      end
      StCsum: if (accept) begin
        if (bus.in_data == csum_q) begin
          error_d    = 1'b0;
          hold_cnt_d = 8'd0;
          state_d    = StHold;
        end else begin
          error_d = 1'b1;
          state_d = StError;
        end
      end
      StHold: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_cnt_q == HoldLast) state_d = StRun;
      end
      // A sync byte only restarts loading once the core has halted.
      StRun: if (accept && is_sync && bus.cpu_halt) state_d = StAddrLo;
      StError: if (accept && is_sync) state_d = StAddrLo;
      default: state_d = StIdle;
    endcase

    if (state_d == StAddrLo && state_q != StAddrLo) begin
      csum_d  = 8'd0;
      error_d = 1'b0;
    end
  end

  // Core is released one cycle after RUN is reached and dropped as soon as RUN is left.
  assign released_d = (state_q == StRun) && (state_d == StRun);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_addr_q  <= 16'd0;
      remaining_q <= 16'd0;
      lo_q        <= 8'd0;
      csum_q      <= 8'd0;
      hold_cnt_q  <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
      released_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      lo_q        <= lo_d;
      csum_q      <= csum_d;
      hold_cnt_q  <= hold_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      released_q  <= released_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_rstn  = released_q;
  assign bus.load_done = released_q;
  assign bus.error     = error_q;
  assign bus.busy      = state_q inside {StAddrLo, StAddrHi, StCntLo, StCntHi, StDataLo,
                                         StDataHi, StCsum};

endmodule
